// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared FSM states and constants for the pipeline controller
package pipeline_pkg;
    typedef enum logic [2:0] {RUN, MEM_WAIT, TRAP_EX, TRAP_DRAIN, TRAP_JUMP} ctrl_state_e;
    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic [31:0] NOP = 32'h00000013;
    function automatic logic is_trap(ctrl_state_e s);
        return s == TRAP_EX || s == TRAP_DRAIN || s == TRAP_JUMP;
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the load in EX and the instruction in ID
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_re,
    output logic       luh
);
    assign luh = ex_mem_re && ex_rd != ZERO_REG &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, flush, memory-freeze and ecall trap sequencing for the 5-stage pipe
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_ecall,
    input  logic [4:0]        ex_rd,
    input  logic              ex_mem_re,
    input  logic              ex_br_taken,
    input  logic [31:0]       ex_br_target,
    input  logic [31:0]       mtvec,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_we,
    output logic              stall_flag,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              trap_busy,
    output logic [PERF_W-1:0] stall_cnt
);
    ctrl_state_e       state_q, state_d, prev_q, prev_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              luh, frz, freeze, in_run, br, ec, lu, drain, jump;

    hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_mem_re   (ex_mem_re),
        .luh         (luh)
    );

    assign frz    = mem_req && !mem_ready;
    assign freeze = frz || state_q == MEM_WAIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            prev_q      <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        stall_cnt_d = (!pc_we && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        if (state_q == MEM_WAIT) begin
            state_d = mem_ready ? prev_q : MEM_WAIT;
        end else if (frz) begin
            state_d = MEM_WAIT;
            prev_d  = state_q;
        end else begin
            case (state_q)
                RUN:        state_d = (id_ecall && !ex_br_taken) ? TRAP_EX : RUN;
                TRAP_EX: begin
                    state_d = TRAP_DRAIN;
                    cnt_d   = 3'(DRAIN_CYCLES);
                end
                TRAP_DRAIN: begin
                    state_d = cnt_q == 3'd0 ? TRAP_JUMP : TRAP_DRAIN;
                    cnt_d   = cnt_q == 3'd0 ? cnt_q : cnt_q - 3'd1;
                end
                default:    state_d = RUN;
            endcase
        end
    end

    // Priority: freeze > taken branch > ecall entry > load-use
    always_comb begin
        in_run       = state_q == RUN && !freeze;
        br           = in_run && ex_br_taken;
        ec           = in_run && !ex_br_taken && id_ecall;
        lu           = in_run && !ex_br_taken && !id_ecall && luh;
        drain        = !freeze && (state_q == TRAP_EX || state_q == TRAP_DRAIN);
        jump         = !freeze && state_q == TRAP_JUMP;
        pc_we        = !(freeze || ec || lu || drain);
        if_id_we     = !(freeze || lu);
        if_id_flush  = br || ec || jump;
        id_ex_bubble = br || lu || drain;
        ex_mem_we    = !freeze;
        stall_flag   = freeze || lu;
        redirect     = br || jump;
        redirect_pc  = jump ? mtvec : br ? ex_br_target : 32'd0;
        trap_busy    = is_trap(state_q) || (state_q == MEM_WAIT && is_trap(prev_q));
    end

    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with a scoreboard queue checked by a separate monitor
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, id_ecall, ex_mem_re, ex_br_taken, mem_req, mem_ready;
    logic [31:0] ex_br_target, mtvec, redirect_pc;
    logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, stall_flag, redirect, trap_busy;
    logic [31:0] stall_cnt;

    typedef struct {
        string       nm;
        logic [7:0]  f;
        logic [31:0] rpc;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vecs = 0, errs = 0;
    logic [7:0] act;

    // flag order: pc_we if_id_we if_id_flush id_ex_bubble ex_mem_we stall_flag redirect trap_busy
    localparam logic [7:0] NORM = 8'b11001000, LUH = 8'b00011100, BR = 8'b11111010,
                           FRZ = 8'b00000100, FRZT = 8'b00000101, ECL = 8'b01101000,
                           TEX = 8'b01011001, JMP = 8'b11101011;

    pipeline_ctrl #(.DRAIN_CYCLES(3), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_ecall(id_ecall),
        .ex_rd(ex_rd), .ex_mem_re(ex_mem_re), .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target), .mtvec(mtvec), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we), .stall_flag(stall_flag),
        .redirect(redirect), .redirect_pc(redirect_pc), .trap_busy(trap_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_ecall = 1'b0;
        ex_mem_re = 1'b0; ex_br_taken = 1'b0; ex_br_target = 32'd0;
        mem_req = 1'b0; mem_ready = 1'b0; mtvec = 32'h100;
    endtask

    task automatic push(string nm, logic [7:0] f, logic [31:0] rpc, logic [31:0] sc);
        sb.push_back('{nm, f, rpc, sc});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, stall_flag, redirect, trap_busy};
                vecs++;
                if (act !== e.f || redirect_pc !== e.rpc || stall_cnt !== e.sc) begin
                    errs++;
                    $display("FAIL %s: got flags=%b rpc=%h cnt=%0d, want flags=%b rpc=%h cnt=%0d",
                             e.nm, act, redirect_pc, stall_cnt, e.f, e.rpc, e.sc);
                end
            end
        end
    end

    initial begin
        next();                                                            push("reset", NORM, 0, 0);
        next(); rst_n = 1'b1;                                              push("idle", NORM, 0, 0);
        next(); ex_mem_re = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;     push("luh_rs1", LUH, 0, 0);
        next();                                                            push("after_luh", NORM, 0, 1);
        next(); ex_mem_re = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;     push("lw_x0", NORM, 0, 1);
        next(); ex_mem_re = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1; id_rs1 = 7;
                                                                           push("luh_rs2", LUH, 0, 1);
        next(); ex_mem_re = 1; ex_rd = 7; id_rs2 = 7; id_rs1 = 7;          push("rs_unused", NORM, 0, 2);
        next(); ex_br_taken = 1; ex_br_target = 32'h80;
                ex_mem_re = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;     push("br_over_luh", BR, 32'h80, 2);
        next(); mem_req = 1; ex_br_taken = 1; ex_br_target = 32'h44;       push("frz_enter", FRZ, 0, 2);
        next(); mem_req = 1; ex_mem_re = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
                                                                           push("frz_w1", FRZ, 0, 3);
        next(); mem_req = 1;                                               push("frz_w2", FRZ, 0, 4);
        next(); mem_req = 1;                                               push("frz_w3", FRZ, 0, 5);
        next(); mem_req = 1; mem_ready = 1;                                push("frz_ready", FRZ, 0, 6);
        next();                                                            push("frz_done", NORM, 0, 7);
        next(); id_ecall = 1;                                              push("ecall", ECL, 0, 7);
        next(); ex_br_taken = 1; ex_br_target = 32'h44; id_ecall = 1;      push("trap_ex", TEX, 0, 8);
        next(); ex_mem_re = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;     push("drain3", TEX, 0, 9);
        next();                                                            push("drain2", TEX, 0, 10);
        next(); mem_req = 1;                                               push("drain_frz", FRZT, 0, 11);
        next(); mem_req = 1; mem_ready = 1;                                push("drain_wait", FRZT, 0, 12);
        next();                                                            push("drain1", TEX, 0, 13);
        next();                                                            push("drain0", TEX, 0, 14);
        next();                                                            push("jump", JMP, 32'h100, 15);
        next();                                                            push("post_trap", NORM, 0, 15);
        next(); id_ecall = 1;                                              push("ecall2", ECL, 0, 15);
        next();                                                            push("trap_ex2", TEX, 0, 16);
        next();                                                            push("drain3b", TEX, 0, 17);
        next(); rst_n = 1'b0;                                              push("rst_mid", NORM, 0, 0);
        next(); rst_n = 1'b1;                                              push("rst_rel", NORM, 0, 0);
        next();                                                            push("rst_idle", NORM, 0, 0);
        next(); ex_mem_re = 1; ex_rd = 9; id_rs2 = 9; id_rs2_used = 1;     push("luh_after_rst", LUH, 0, 0);
        next();                                                            push("final", NORM, 0, 1);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain_queue: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
